// File: rtl/sysex_param_parser_if.sv
// Byte-in / commit-out bundle for the SysEx parameter parser.
interface sysex_param_parser_if;
  logic [7:0] midi_byte;
  logic       byte_ready;
  logic [2:0] bank_adr;
  logic [6:0] syx_adr;
  logic [7:0] syx_data;
  logic       data_ready;
  logic       busy;
  logic       syx_err;

  // Byte source side: drives received bytes, observes committed parameters.
  modport master (
    output midi_byte, byte_ready,
    input  bank_adr, syx_adr, syx_data, data_ready, busy, syx_err
  );

  // Parser side.
  modport slave (
    input  midi_byte, byte_ready,
    output bank_adr, syx_adr, syx_data, data_ready, busy, syx_err
  );
endinterface

// File: rtl/sysex_param_parser.sv
// Parses F0 ID BANK ADR DHI DLO F7 SysEx parameter frames and commits
// bank/address/value with a fixed-length data_ready strobe.
module sysex_param_parser #(
  parameter logic [6:0]  MFR_ID = 7'h7D,
  parameter int unsigned DR_LEN = 8
) (
  input  logic                  CLOCK_25,
  input  logic                  reset_reg,
  sysex_param_parser_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_BANK = 3'd2;
  localparam logic [2:0] S_ADR  = 3'd3;
  localparam logic [2:0] S_DHI  = 3'd4;
  localparam logic [2:0] S_DLO  = 3'd5;
  localparam logic [2:0] S_EOX  = 3'd6;

  localparam logic [7:0] DR_INIT = 8'(DR_LEN);

  logic [2:0] state;
  logic [2:0] sh_bank;
  logic [6:0] sh_adr;
  logic       sh_dhi;
  logic [6:0] sh_dlo;
  logic [2:0] bank_q;
  logic [6:0] adr_q;
  logic [7:0] data_q;
  logic [7:0] dr_cnt;
  logic       err_q;

  logic [7:0] b;
  logic       is_rt;
  logic       is_f0;
  logic       is_f7;
  logic       is_data;
  logic       dr_on;

  // Byte classification.
  always_comb begin
    b       = bus.midi_byte;
    is_rt   = (b[7:3] == 5'b11111);
    is_f0   = (b == 8'hF0);
    is_f7   = (b == 8'hF7);
    is_data = ~b[7];
    dr_on   = (dr_cnt != '0);
  end

  // Frame FSM, shadow capture, commit and data_ready countdown.
  always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
    if (reset_reg) begin
      state   <= S_IDLE;
      sh_bank <= '0;
      sh_adr  <= '0;
      sh_dhi  <= 1'b0;
      sh_dlo  <= '0;
      bank_q  <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      dr_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (dr_on) dr_cnt <= dr_cnt - 8'd1;
      if (bus.byte_ready && !is_rt) begin
        if (is_f0) begin
          // Restarting from ID itself loses nothing worth flagging.
          if (state != S_IDLE && state != S_ID) err_q <= 1'b1;
          state <= S_ID;
        end else if (state == S_IDLE) begin
          state <= S_IDLE;
        end else if (!is_data) begin
          if (state == S_EOX && is_f7) begin
            if (dr_on) begin
              err_q <= 1'b1;
            end else begin
              bank_q <= sh_bank;
              adr_q  <= sh_adr;
              data_q <= {sh_dhi, sh_dlo};
              dr_cnt <= DR_INIT;
            end
          end else begin
            err_q <= 1'b1;
          end
          state <= S_IDLE;
        end else begin
          case (state)
            S_ID:   state <= (b[6:0] == MFR_ID) ? S_BANK : S_IDLE;
            S_BANK: begin
              if (b[6:3] != 4'd0) begin
                err_q <= 1'b1;
                state <= S_IDLE;
              end else begin
                sh_bank <= b[2:0];
                state   <= S_ADR;
              end
            end
            S_ADR: begin
              sh_adr <= b[6:0];
              state  <= S_DHI;
            end
            S_DHI: begin
              sh_dhi <= b[0];
              state  <= S_DLO;
            end
            S_DLO: begin
              sh_dlo <= b[6:0];
              state  <= S_EOX;
            end
            S_EOX: begin
              err_q <= 1'b1;
              state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.bank_adr   = bank_q;
  assign bus.syx_adr    = adr_q;
  assign bus.syx_data   = data_q;
  assign bus.data_ready = dr_on;
  assign bus.busy       = dr_on;
  assign bus.syx_err    = err_q;

endmodule

// File: tb/tb_sysex_param_parser.sv
// Randomized and directed bench for sysex_param_parser against a
// frame-level reference model.
module tb_sysex_param_parser;

  localparam int DR_LEN = 8;
  localparam logic [7:0] MFR = 8'h7D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sysex_param_parser_if bus();

  sysex_param_parser #(.MFR_ID(7'h7D), .DR_LEN(DR_LEN)) dut (
    .CLOCK_25 (clk),
    .reset_reg(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bytes of the current frame after F0.
  bit        in_frame;
  bit [7:0]  frm[$];
  bit [2:0]  m_bank;
  bit [6:0]  m_adr;
  bit [7:0]  m_data;
  int        cyc;
  int        commit_cyc;
  bit        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit dr_at(input int n);
    return (n >= commit_cyc) && (n - commit_cyc < DR_LEN);
  endfunction

  task automatic model_reset();
    in_frame = 1'b0;
    frm.delete();
    m_bank = '0;
    m_adr = '0;
    m_data = '0;
    commit_cyc = -1000;
    exp_err = 1'b0;
  endtask

  // Applies one clock edge to the model.
  task automatic model_edge(input bit v, input bit [7:0] b);
    bit busy_pre;
    cyc++;
    busy_pre = dr_at(cyc - 1);
    exp_err = 1'b0;
    if (!v || b >= 8'hF8) return;
    if (b == 8'hF0) begin
      if (in_frame && frm.size() >= 1) exp_err = 1'b1;
      in_frame = 1'b1;
      frm.delete();
    end else if (!in_frame) begin
      // ignored in idle
    end else if (b[7]) begin
      if (b == 8'hF7 && frm.size() == 5) begin
        if (busy_pre) exp_err = 1'b1;
        else begin
          m_bank = frm[1][2:0];
          m_adr  = frm[2][6:0];
          m_data = {frm[3][0], frm[4][6:0]};
          commit_cyc = cyc;
        end
      end else begin
        exp_err = 1'b1;
      end
      in_frame = 1'b0;
    end else begin
      frm.push_back(b);
      if (frm.size() == 1 && b != MFR) in_frame = 1'b0;
      else if (frm.size() == 2 && b[6:3] != 4'd0) begin
        exp_err = 1'b1;
        in_frame = 1'b0;
      end else if (frm.size() == 6) begin
        exp_err = 1'b1;
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("bank_adr", 32'(bus.bank_adr), 32'(m_bank));
    check("syx_adr", 32'(bus.syx_adr), 32'(m_adr));
    check("syx_data", 32'(bus.syx_data), 32'(m_data));
    check("data_ready", 32'(bus.data_ready), 32'(dr_at(cyc)));
    check("busy", 32'(bus.busy), 32'(dr_at(cyc)));
    check("syx_err", 32'(bus.syx_err), 32'(exp_err));
  endtask

  // Called at a negedge: drive, clock, model, check at next negedge.
  task automatic step(input bit v, input bit [7:0] b);
    bus.midi_byte  = b;
    bus.byte_ready = v;
    @(posedge clk);
    model_edge(v, b);
    @(negedge clk);
    bus.byte_ready = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input bit [7:0] q[$]);
    foreach (q[i]) step(1'b1, q[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_bank", 32'(bus.bank_adr), 32'd0);
    check("rst_async_dr", 32'(bus.data_ready), 32'd0);
    check("rst_async_data", 32'(bus.syx_data), 32'd0);
    repeat (2) begin
      @(posedge clk);
      model_edge(1'b0, 8'h00);
    end
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  int dr_high;

  initial begin
    bus.midi_byte = '0;
    bus.byte_ready = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    idle(2);

    // Basic frame, data_ready length counted independently.
    send('{8'hF0, 8'h7D, 8'h05, 8'h12, 8'h01, 8'h34, 8'hF7});
    check("r032_bank", 32'(bus.bank_adr), 32'd5);
    check("r032_adr", 32'(bus.syx_adr), 32'h12);
    check("r032_data", 32'(bus.syx_data), 32'hB4);
    check("r032_dr_first", 32'(bus.data_ready), 32'd1);
    dr_high = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00);
      if (bus.data_ready) dr_high++;
    end
    check("r032_dr_len", 32'(dr_high), 32'(DR_LEN));

    // Realtime bytes interleaved.
    send('{8'hF0, 8'h7D, 8'h02, 8'hF8, 8'h10, 8'hFE, 8'h00, 8'h7F, 8'hF7});
    check("r033_bank", 32'(bus.bank_adr), 32'd2);
    check("r033_data", 32'(bus.syx_data), 32'h7F);
    idle(10);

    // Bad bank byte.
    send('{8'hF0, 8'h7D, 8'h09});
    check("r034_err", 32'(bus.syx_err), 32'd1);
    send('{8'h12, 8'h01, 8'h34, 8'hF7});
    check("r034_held", 32'(bus.syx_adr), 32'h10);
    idle(3);

    // Foreign ID, then valid frame.
    send('{8'hF0, 8'h41, 8'h05, 8'h12, 8'h01, 8'h34, 8'hF7});
    send('{8'hF0, 8'h7D, 8'h01, 8'h00, 8'h00, 8'h00, 8'hF7});
    check("r035_bank", 32'(bus.bank_adr), 32'd1);
    check("r035_data", 32'(bus.syx_data), 32'd0);
    idle(10);

    // Status mid-frame and over-long frame.
    send('{8'hF0, 8'h7D, 8'h03, 8'h20, 8'h90});
    check("r036_status_err", 32'(bus.syx_err), 32'd1);
    send('{8'hF0, 8'h7D, 8'h03, 8'h20, 8'h00, 8'h01, 8'h05});
    check("r036_long_err", 32'(bus.syx_err), 32'd1);
    send('{8'hF7});
    idle(3);

    // Frame B while A's data_ready still high, then reset mid-frame.
    send('{8'hF0, 8'h7D, 8'h06, 8'h33, 8'h00, 8'h44, 8'hF7});
    send('{8'hF0, 8'h7D, 8'h01, 8'h11, 8'h01, 8'h22, 8'hF7});
    check("r037_drop_err", 32'(bus.syx_err), 32'd1);
    check("r037_held", 32'(bus.syx_adr), 32'h33);
    idle(2);
    send('{8'hF0, 8'h7D, 8'h04, 8'h55, 8'h01});
    do_reset();
    check("r037_rst_adr", 32'(bus.syx_adr), 32'd0);
    send('{8'h66, 8'hF7});
    idle(3);

    // Randomized frames with mutations and varying gaps.
    for (int f = 0; f < 300; f++) begin
      bit [7:0] q[$];
      q.delete();
      q.push_back(8'hF0);
      q.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 127)) : MFR);
      q.push_back(($urandom_range(0, 6) == 0) ? 8'($urandom_range(8, 127)) : 8'($urandom_range(0, 7)));
      for (int k = 0; k < 3; k++) q.push_back(8'($urandom_range(0, 127)));
      q.push_back(8'hF7);
      if ($urandom_range(0, 6) == 0) q.insert($urandom_range(1, 6), 8'($urandom_range(8'hF8, 8'hFF)));
      if ($urandom_range(0, 9) == 0) q[$urandom_range(1, 6)] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 12) == 0) q.insert(q.size() - 1, 8'($urandom_range(0, 127)));
      if ($urandom_range(0, 12) == 0) void'(q.pop_back());
      if ($urandom_range(0, 40) == 0) q.insert($urandom_range(2, 5), 8'hF0);
      foreach (q[i]) begin
        step(1'b1, q[i]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if ($urandom_range(0, 5) == 0) step(1'b1, 8'($urandom_range(0, 255)));
      idle($urandom_range(0, 12));
      if (f == 150) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1);
  end

endmodule
